cw305_reg_bus_arbiter: RTL and testbench
========================================

// Module: cw305_reg_bus_arbiter
// PURPOSE
// Shares the internal register bus (reg_address/reg_bytecnt/write_data/reg_read/reg_write/reg_addrvalid/read_data)
// between two requesters: m0 = USB register front end, m1 = SimpleSerial2 register bridge. Round-robin,
// burst-locked on addrvalid, registered bus outputs, read data routed back to the issuer, and an ownership watchdog.
// Sits between the front ends and the register file (e.g. cw305_reg_test_ss2) in the top level.
// PARAMETERS
// pBYTECNT_SIZE  8     width of reg_bytecnt
// pADDR_WIDTH    32    full address width; reg_address width AW = pADDR_WIDTH-pBYTECNT_SIZE
// pREAD_LAT      2     cycles from reg_read asserted on the bus to read_data valid; legal range 1..8
// pTIMEOUT       1024  idle-owner cycles before forced release; 0 disables; counter is 16 bits
// PORTS
// usb_clk        in   1    single clock
// resetn         in   1    synchronous, active-low reset
// mX_addrvalid   in   1    (X=0,1) bus request / burst lock
// mX_address     in   AW   register address
// mX_bytecnt     in   pBYTECNT_SIZE  byte index
// mX_wdata       in   8    write data
// mX_read        in   1    1-cycle read strobe; honoured only while mX_grant=1
// mX_write       in   1    1-cycle write strobe; honoured only while mX_grant=1
// mX_grant       out  1    requester owns the bus
// mX_rdata       out  8    returned read data; holds last value
// mX_rvalid      out  1    1-cycle pulse, mX_rdata valid
// reg_address    out  AW   to register file
// reg_bytecnt    out  pBYTECNT_SIZE
// write_data     out  8
// reg_read       out  1
// reg_write      out  1
// reg_addrvalid  out  1
// read_data      in   8    from register file
// err_clr        in   1    clears timeout_err
// timeout_err    out  1    sticky: watchdog fired
// owner          out  1    last granted requester (0/1)
// BEHAVIOUR
// - Reset (resetn=0 at posedge): state IDLE, all outputs 0, rr pointer last=1 (m0 wins first tie),
//   read tracking pipe cleared (pending reads never return rvalid), timeout counter 0, block flags 0.
// - FSM IDLE -> OWN0/OWN1 -> DRAIN -> IDLE.
// - IDLE: request = mX_addrvalid & !blockX. One requester: grant it. Both: grant !last. Enter OWNx and assert
//   mX_grant at next edge (grant latency 1 cycle); owner and last updated at the same edge.
// - OWNx: bus outputs registered from owner inputs, 1-cycle latency: reg_address/reg_bytecnt/write_data <= mX_*,
//   reg_read <= mX_read & !mX_write, reg_write <= mX_write (write wins if both high), reg_addrvalid <= mX_addrvalid.
//   Non-owner strobes ignored, never reach the bus; its grant stays 0.
// - Release: owner mX_addrvalid=0 sampled -> grant drops next edge, go DRAIN. reg_addrvalid low the same edge.
// - DRAIN: stays until no read is in flight (pREAD_LAT-deep tag pipe empty), minimum 1 cycle; then IDLE. New grant
//   earliest 2 cycles after release sample.
// - Read return: read_data sampled exactly pREAD_LAT cycles after reg_read=1 on the bus; steered by tag to issuer's
//   mX_rdata with mX_rvalid pulse. Back-to-back reads each return one pulse, in order.
// - Watchdog (pTIMEOUT>0): counter runs in OWNx, resets on any owner strobe; reaching pTIMEOUT forces DRAIN,
//   sets timeout_err and blockX. blockX clears when mX_addrvalid=0 sampled. err_clr clears timeout_err; fire and
//   clear in the same cycle -> timeout_err stays 1.
// - Counter saturates, no wrap. Idle bus: reg_* strobes 0, address/bytecnt/data hold last value.
// TESTING
// - m0 only, addr 0x12, bytecnt 3, write 0xA5 -> m0_grant 1 cycle after request; reg_write pulse 1 cycle after strobe.
//   Bus shows 0x12/3/0xA5.
// - Both request in the same cycle after reset -> m0 granted first. After m0 releases, m1 granted 2 cycles later.
//   Next tie -> m0.
// - m1 owns, m0 strobes write 0x55 -> no reg_write for m0. m1 read, read_data=0x3C at lat 2 -> m1_rvalid pulse,
//   m1_rdata=0x3C, m0_rvalid stays 0.
// - pREAD_LAT=2, owner issues 3 back-to-back reads then drops addrvalid -> 3 rvalid pulses in order.
//   Grant is not given to the other requester until the last read has returned.
// - pTIMEOUT=16, m0 holds addrvalid with no strobes -> grant drops after 16 cycles, timeout_err=1.
//   m0 not regranted until addrvalid toggles low. err_clr -> timeout_err=0.
// - resetn low mid-read -> all outputs 0 next edge, no rvalid emitted. After reset, tie -> m0.

Source files
------------

// File: rtl/cw305_reg_bus_arbiter_if.sv
// Register bus bundle between the two requesters, the arbiter and the register file.
// The arbiter takes the slave view; the requesters and the register file together take the master view.
interface cw305_reg_bus_arbiter_if #(
  parameter int AW = 24,
  parameter int BW = 8
);
  logic          m0_addrvalid;
  logic [AW-1:0] m0_address;
  logic [BW-1:0] m0_bytecnt;
  logic [7:0]    m0_wdata;
  logic          m0_read;
  logic          m0_write;
  logic          m0_grant;
  logic [7:0]    m0_rdata;
  logic          m0_rvalid;

  logic          m1_addrvalid;
  logic [AW-1:0] m1_address;
  logic [BW-1:0] m1_bytecnt;
  logic [7:0]    m1_wdata;
  logic          m1_read;
  logic          m1_write;
  logic          m1_grant;
  logic [7:0]    m1_rdata;
  logic          m1_rvalid;

  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_bytecnt;
  logic [7:0]    write_data;
  logic          reg_read;
  logic          reg_write;
  logic          reg_addrvalid;
  logic [7:0]    read_data;

  modport slave (
    input  m0_addrvalid, m0_address, m0_bytecnt, m0_wdata, m0_read, m0_write,
    output m0_grant, m0_rdata, m0_rvalid,
    input  m1_addrvalid, m1_address, m1_bytecnt, m1_wdata, m1_read, m1_write,
    output m1_grant, m1_rdata, m1_rvalid,
    output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    input  read_data
  );

  modport master (
    output m0_addrvalid, m0_address, m0_bytecnt, m0_wdata, m0_read, m0_write,
    input  m0_grant, m0_rdata, m0_rvalid,
    output m1_addrvalid, m1_address, m1_bytecnt, m1_wdata, m1_read, m1_write,
    input  m1_grant, m1_rdata, m1_rvalid,
    input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    output read_data
  );
endinterface

// File: rtl/cw305_reg_bus_arbiter.sv
// Round-robin, burst-locked arbiter sharing the register bus between the USB front end (m0)
// and the SimpleSerial2 bridge (m1), with tagged read return and an ownership watchdog.
//
// state   | meaning
// S_IDLE  | bus free, arbitrate between unblocked requesters
// S_OWN0  | m0 owns the bus, its inputs are registered onto the bus
// S_OWN1  | m1 owns the bus, its inputs are registered onto the bus
// S_DRAIN | ownership released, waiting for in-flight reads to return
module cw305_reg_bus_arbiter #(
  parameter int pBYTECNT_SIZE = 8,
  parameter int pADDR_WIDTH   = 32,
  parameter int pREAD_LAT     = 2,
  parameter int pTIMEOUT      = 1024
) (
  input  logic usb_clk,
  input  logic resetn,
  cw305_reg_bus_arbiter_if.slave bus,
  input  logic err_clr,
  output logic timeout_err,
  output logic owner
);

  localparam int          AW         = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam logic [15:0] LP_TIMEOUT = 16'(pTIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1, S_DRAIN} state_t;

  state_t                   r_state;
  logic                     r_last;
  logic                     r_owner;
  logic                     r_grant0, r_grant1;
  logic                     r_block0, r_block1;
  logic                     r_timeout_err;
  logic [15:0]              r_wd_cnt;
  logic [AW-1:0]            r_reg_address;
  logic [pBYTECNT_SIZE-1:0] r_reg_bytecnt;
  logic [7:0]               r_write_data;
  logic                     r_reg_read, r_reg_write, r_reg_addrvalid;
  logic                     r_reg_tag;
  logic [pREAD_LAT-1:0]     r_pipe_v;
  logic [pREAD_LAT-1:0]     r_pipe_tag;
  logic [7:0]               r_m0_rdata, r_m1_rdata;
  logic                     r_m0_rvalid, r_m1_rvalid;

  logic                     w_req0, w_req1, w_pick1, w_own1;
  logic                     w_av, w_rd, w_wr, w_strobe, w_fire, w_inflight;
  logic [AW-1:0]            w_addr;
  logic [pBYTECNT_SIZE-1:0] w_bc;
  logic [7:0]               w_wd;
  logic [15:0]              w_cnt_nxt;

  assign w_req0  = bus.m0_addrvalid & ~r_block0;
  assign w_req1  = bus.m1_addrvalid & ~r_block1;
  // On a tie the requester that was not granted last time wins.
  assign w_pick1 = w_req1 & (~w_req0 | ~r_last);

  assign w_own1   = (r_state == S_OWN1);
  assign w_av     = w_own1 ? bus.m1_addrvalid : bus.m0_addrvalid;
  assign w_rd     = w_own1 ? bus.m1_read      : bus.m0_read;
  assign w_wr     = w_own1 ? bus.m1_write     : bus.m0_write;
  assign w_addr   = w_own1 ? bus.m1_address   : bus.m0_address;
  assign w_bc     = w_own1 ? bus.m1_bytecnt   : bus.m0_bytecnt;
  assign w_wd     = w_own1 ? bus.m1_wdata     : bus.m0_wdata;
  assign w_strobe = w_rd | w_wr;

  assign w_cnt_nxt = (r_wd_cnt == 16'hFFFF) ? r_wd_cnt : r_wd_cnt + 16'd1;
  assign w_fire    = (pTIMEOUT != 0) && (w_cnt_nxt >= LP_TIMEOUT);

  // The last pipe stage is consumed on this edge, so it no longer counts as in flight.
  always_comb begin
    w_inflight = r_reg_read;
    for (int i = 0; i < pREAD_LAT - 1; i++) w_inflight = w_inflight | r_pipe_v[i];
  end

  always_ff @(posedge usb_clk) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_last          <= 1'b1;
      r_owner         <= 1'b0;
      r_grant0        <= 1'b0;
      r_grant1        <= 1'b0;
      r_block0        <= 1'b0;
      r_block1        <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_wd_cnt        <= '0;
      r_reg_address   <= '0;
      r_reg_bytecnt   <= '0;
      r_write_data    <= '0;
      r_reg_read      <= 1'b0;
      r_reg_write     <= 1'b0;
      r_reg_addrvalid <= 1'b0;
      r_reg_tag       <= 1'b0;
      r_pipe_v        <= '0;
      r_pipe_tag      <= '0;
      r_m0_rdata      <= '0;
      r_m1_rdata      <= '0;
      r_m0_rvalid     <= 1'b0;
      r_m1_rvalid     <= 1'b0;
    end else begin
      r_m0_rvalid     <= 1'b0;
      r_m1_rvalid     <= 1'b0;
      r_reg_read      <= 1'b0;
      r_reg_write     <= 1'b0;
      r_reg_addrvalid <= 1'b0;

      r_pipe_v[0]   <= r_reg_read;
      r_pipe_tag[0] <= r_reg_tag;
      for (int i = 1; i < pREAD_LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end

      if (r_pipe_v[pREAD_LAT-1]) begin
        if (r_pipe_tag[pREAD_LAT-1]) begin
          r_m1_rdata  <= bus.read_data;
          r_m1_rvalid <= 1'b1;
        end else begin
          r_m0_rdata  <= bus.read_data;
          r_m0_rvalid <= 1'b1;
        end
      end

      if (!bus.m0_addrvalid) r_block0 <= 1'b0;
      if (!bus.m1_addrvalid) r_block1 <= 1'b0;
      if (err_clr) r_timeout_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_wd_cnt <= '0;
          if (w_req0 | w_req1) begin
            r_owner  <= w_pick1;
            r_last   <= w_pick1;
            r_grant0 <= ~w_pick1;
            r_grant1 <= w_pick1;
            r_state  <= w_pick1 ? S_OWN1 : S_OWN0;
          end
        end
        S_OWN0, S_OWN1: begin
          r_reg_address   <= w_addr;
          r_reg_bytecnt   <= w_bc;
          r_write_data    <= w_wd;
          r_reg_read      <= w_rd & ~w_wr;
          r_reg_write     <= w_wr;
          r_reg_addrvalid <= w_av;
          r_reg_tag       <= w_own1;
          if (!w_av) begin
            r_state  <= S_DRAIN;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_wd_cnt <= '0;
          end else if (w_strobe) begin
            r_wd_cnt <= '0;
          end else if (w_fire) begin
            r_state         <= S_DRAIN;
            r_grant0        <= 1'b0;
            r_grant1        <= 1'b0;
            r_wd_cnt        <= '0;
            r_reg_addrvalid <= 1'b0;
            r_timeout_err   <= 1'b1;
            if (w_own1) r_block1 <= 1'b1;
            else        r_block0 <= 1'b1;
          end else begin
            r_wd_cnt <= w_cnt_nxt;
          end
        end
        S_DRAIN: begin
          if (!w_inflight) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m0_grant      = r_grant0;
  assign bus.m1_grant      = r_grant1;
  assign bus.m0_rdata      = r_m0_rdata;
  assign bus.m1_rdata      = r_m1_rdata;
  assign bus.m0_rvalid     = r_m0_rvalid;
  assign bus.m1_rvalid     = r_m1_rvalid;
  assign bus.reg_address   = r_reg_address;
  assign bus.reg_bytecnt   = r_reg_bytecnt;
  assign bus.write_data    = r_write_data;
  assign bus.reg_read      = r_reg_read;
  assign bus.reg_write     = r_reg_write;
  assign bus.reg_addrvalid = r_reg_addrvalid;
  assign timeout_err       = r_timeout_err;
  assign owner             = r_owner;

endmodule

// File: tb/tb_cw305_reg_bus_arbiter.sv
// Directed bench for cw305_reg_bus_arbiter: arbitration, bus registering, read steering,
// drain behaviour, watchdog and reset, with a 2-cycle register file model returning address[7:0].
module tb_cw305_reg_bus_arbiter;

  localparam int LP_AW = 24;

  logic usb_clk;
  logic resetn;
  logic err_clr;
  logic timeout_err;
  logic owner;

  int n_chk = 0;
  int n_err = 0;

  cw305_reg_bus_arbiter_if #(.AW(LP_AW), .BW(8)) bus_if ();

  cw305_reg_bus_arbiter #(
    .pBYTECNT_SIZE(8),
    .pADDR_WIDTH  (32),
    .pREAD_LAT    (2),
    .pTIMEOUT     (16)
  ) dut (
    .usb_clk    (usb_clk),
    .resetn     (resetn),
    .bus        (bus_if.slave),
    .err_clr    (err_clr),
    .timeout_err(timeout_err),
    .owner      (owner)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  // Register file model: data for a read appears two cycles after reg_read, equal to address[7:0].
  logic [1:0] tb_rv;
  logic [7:0] tb_ra0, tb_ra1;
  always @(posedge usb_clk) begin
    tb_rv  <= {tb_rv[0], bus_if.reg_read};
    tb_ra0 <= bus_if.reg_address[7:0];
    tb_ra1 <= tb_ra0;
  end
  assign bus_if.read_data = tb_rv[1] ? tb_ra1 : 8'h00;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    tb_rv  = '0;
    tb_ra0 = '0;
    tb_ra1 = '0;
    resetn = 1'b0;
    err_clr = 1'b0;
    bus_if.m0_addrvalid = 0; bus_if.m0_address = '0; bus_if.m0_bytecnt = '0;
    bus_if.m0_wdata = '0; bus_if.m0_read = 0; bus_if.m0_write = 0;
    bus_if.m1_addrvalid = 0; bus_if.m1_address = '0; bus_if.m1_bytecnt = '0;
    bus_if.m1_wdata = '0; bus_if.m1_read = 0; bus_if.m1_write = 0;

    // Reset state
    do_reset();
    check_val("rst_m0_grant", 32'(bus_if.m0_grant), 0);
    check_val("rst_m1_grant", 32'(bus_if.m1_grant), 0);
    check_val("rst_reg_addrvalid", 32'(bus_if.reg_addrvalid), 0);
    check_val("rst_reg_write", 32'(bus_if.reg_write), 0);
    check_val("rst_reg_address", 32'(bus_if.reg_address), 0);
    check_val("rst_timeout_err", 32'(timeout_err), 0);
    check_val("rst_owner", 32'(owner), 0);

    // m0 alone writes 0xA5 to 0x12 byte 3
    bus_if.m0_addrvalid = 1; bus_if.m0_address = 24'h12; bus_if.m0_bytecnt = 8'd3; bus_if.m0_wdata = 8'hA5;
    tick();
    check_val("w_m0_grant", 32'(bus_if.m0_grant), 1);
    check_val("w_m1_grant", 32'(bus_if.m1_grant), 0);
    bus_if.m0_write = 1;
    tick();
    check_val("w_reg_write", 32'(bus_if.reg_write), 1);
    check_val("w_reg_address", 32'(bus_if.reg_address), 32'h12);
    check_val("w_reg_bytecnt", 32'(bus_if.reg_bytecnt), 3);
    check_val("w_write_data", 32'(bus_if.write_data), 32'hA5);
    check_val("w_reg_addrvalid", 32'(bus_if.reg_addrvalid), 1);
    bus_if.m0_read = 1;
    tick();
    check_val("rw_write_wins", 32'(bus_if.reg_write), 1);
    check_val("rw_no_read", 32'(bus_if.reg_read), 0);
    bus_if.m0_write = 0; bus_if.m0_read = 0;
    tick();
    check_val("w_reg_write_pulse", 32'(bus_if.reg_write), 0);
    bus_if.m0_addrvalid = 0;
    tick();
    check_val("rel_m0_grant", 32'(bus_if.m0_grant), 0);
    check_val("rel_reg_addrvalid", 32'(bus_if.reg_addrvalid), 0);
    tick();
    tick();
    check_val("idle_addr_hold", 32'(bus_if.reg_address), 32'h12);

    // Tie after reset: m0 first, m1 two cycles after release, next tie m0
    do_reset();
    bus_if.m0_addrvalid = 1; bus_if.m1_addrvalid = 1;
    tick();
    check_val("tie_m0_grant", 32'(bus_if.m0_grant), 1);
    check_val("tie_m1_grant", 32'(bus_if.m1_grant), 0);
    tick();
    bus_if.m0_addrvalid = 0;
    tick();
    check_val("tie_rel_m1_grant0", 32'(bus_if.m1_grant), 0);
    tick();
    check_val("tie_rel_m1_grant1", 32'(bus_if.m1_grant), 0);
    tick();
    check_val("tie_m1_granted", 32'(bus_if.m1_grant), 1);
    check_val("tie_owner1", 32'(owner), 1);
    bus_if.m0_addrvalid = 1; bus_if.m1_addrvalid = 0;
    tick();
    bus_if.m1_addrvalid = 1;
    tick();
    tick();
    check_val("tie2_m0_grant", 32'(bus_if.m0_grant), 1);
    check_val("tie2_m1_grant", 32'(bus_if.m1_grant), 0);

    // m1 owns; m0 strobes are ignored, m1 read returns 0x3C
    bus_if.m0_addrvalid = 0;
    tick();
    tick();
    tick();
    check_val("own_m1_grant", 32'(bus_if.m1_grant), 1);
    bus_if.m0_write = 1; bus_if.m0_wdata = 8'h55;
    bus_if.m1_read = 1; bus_if.m1_address = 24'h3C;
    tick();
    check_val("m0_write_blocked", 32'(bus_if.reg_write), 0);
    check_val("m1_reg_read", 32'(bus_if.reg_read), 1);
    check_val("m1_reg_address", 32'(bus_if.reg_address), 32'h3C);
    bus_if.m0_write = 0; bus_if.m1_read = 0;
    tick();
    check_val("rd_rvalid_early1", 32'(bus_if.m1_rvalid), 0);
    tick();
    check_val("rd_rvalid_early2", 32'(bus_if.m1_rvalid), 0);
    tick();
    check_val("rd_m1_rvalid", 32'(bus_if.m1_rvalid), 1);
    check_val("rd_m1_rdata", 32'(bus_if.m1_rdata), 32'h3C);
    check_val("rd_m0_rvalid", 32'(bus_if.m0_rvalid), 0);
    tick();
    check_val("rd_m1_rvalid_pulse", 32'(bus_if.m1_rvalid), 0);

    // Three back-to-back reads, then release; m0 waits for the last return
    for (int i = 1; i <= 3; i++) begin
      bus_if.m1_read = 1; bus_if.m1_address = 24'(i);
      tick();
    end
    bus_if.m1_read = 0; bus_if.m1_addrvalid = 0; bus_if.m0_addrvalid = 1;
    tick();
    check_val("b2b_rv1", 32'(bus_if.m1_rvalid), 1);
    check_val("b2b_rd1", 32'(bus_if.m1_rdata), 1);
    check_val("b2b_m1_grant_drop", 32'(bus_if.m1_grant), 0);
    tick();
    check_val("b2b_rv2", 32'(bus_if.m1_rvalid), 1);
    check_val("b2b_rd2", 32'(bus_if.m1_rdata), 2);
    check_val("b2b_m0_wait2", 32'(bus_if.m0_grant), 0);
    tick();
    check_val("b2b_rv3", 32'(bus_if.m1_rvalid), 1);
    check_val("b2b_rd3", 32'(bus_if.m1_rdata), 3);
    check_val("b2b_m0_wait3", 32'(bus_if.m0_grant), 0);
    tick();
    check_val("b2b_rv_done", 32'(bus_if.m1_rvalid), 0);
    check_val("b2b_m0_grant", 32'(bus_if.m0_grant), 1);

    // Watchdog: m0 holds the bus idle for 16 cycles
    repeat (15) tick();
    check_val("wd_grant_held", 32'(bus_if.m0_grant), 1);
    check_val("wd_err_before", 32'(timeout_err), 0);
    tick();
    check_val("wd_grant_drop", 32'(bus_if.m0_grant), 0);
    check_val("wd_err_set", 32'(timeout_err), 1);
    repeat (5) tick();
    check_val("wd_blocked", 32'(bus_if.m0_grant), 0);
    bus_if.m0_addrvalid = 0;
    tick();
    bus_if.m0_addrvalid = 1;
    tick();
    check_val("wd_regrant", 32'(bus_if.m0_grant), 1);
    check_val("wd_err_sticky", 32'(timeout_err), 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    check_val("wd_err_clr", 32'(timeout_err), 0);

    // Reset in the middle of a read
    bus_if.m0_read = 1; bus_if.m0_address = 24'h44;
    tick();
    check_val("mr_reg_read", 32'(bus_if.reg_read), 1);
    bus_if.m0_read = 0;
    tick();
    resetn = 0; bus_if.m1_addrvalid = 1;
    tick();
    check_val("mr_m0_grant", 32'(bus_if.m0_grant), 0);
    check_val("mr_reg_addrvalid", 32'(bus_if.reg_addrvalid), 0);
    check_val("mr_reg_address", 32'(bus_if.reg_address), 0);
    check_val("mr_m0_rvalid", 32'(bus_if.m0_rvalid), 0);
    resetn = 1;
    tick();
    check_val("mr_no_rvalid", 32'(bus_if.m0_rvalid), 0);
    check_val("mr_tie_m0", 32'(bus_if.m0_grant), 1);
    check_val("mr_tie_m1", 32'(bus_if.m1_grant), 0);
    tick();
    check_val("mr_no_rvalid2", 32'(bus_if.m0_rvalid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
